mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Sequential arbiter sharing the single-ported RAM between the instruction-fetch and data-access requests issued by the request unit of the single-cycle datapath. It grants one requester at a time, holds the grant until the RAM reports completion, and returns the `ihit`/`dhit` pulses and load data that the request unit and datapath consume. It sits between the request unit / CPU memory signals and the RAM model, and adds round-robin fairness, halt gating and a RAM timeout error.

## Interface
- `TIMEOUT`, 16: max cycles a grant waits for `ram_ready` before abort (≥2).
- `AW`, 32: address width.
- `DW`, 32: data width.

- `CLK`  in  1  clock, rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `imemREN`  in  1  instruction read request.
- `imemaddr`  in  AW  instruction address.
- `dmemREN`  in  1  data read request.
- `dmemWEN`  in  1  data write request.
- `dmemaddr`  in  AW  data address.
- `dmemstore`  in  DW  data store value.
- `halt`  in  1  CPU halted; blocks new instruction grants.
- `ram_ready`  in  1  RAM completes current access this cycle.
- `ram_load`  in  DW  RAM read data, valid with `ram_ready`.
- `ram_ren`  out  1  RAM read strobe.
- `ram_wen`  out  1  RAM write strobe.
- `ram_addr`  out  AW  RAM address.
- `ram_store`  out  DW  RAM write data.
- `ihit`  out  1  instruction access done (1-cycle pulse).
- `dhit`  out  1  data access done (1-cycle pulse).
- `imemload`  out  DW  instruction data.
- `dmemload`  out  DW  data read data.
- `err`  out  1  sticky timeout flag.

## Operation
- FSM states: IDLE, IACC, DACC. Registered state, `last_d` flag, timeout counter `cnt` (width clog2(TIMEOUT+1)), sticky `err`.
- Pending: `dreq = dmemREN | dmemWEN`; `ireq = imemREN & ~halt`.
- IDLE: dreq only → DACC; ireq only → IACC; both → IACC if `last_d`=1, else DACC; none → stay.
- Entering DACC sets `last_d`=1; entering IACC clears it.
- IACC: `ram_ren`=1, `ram_addr`=`imemaddr`. DACC: `ram_addr`=`dmemaddr`; `dmemWEN`=1 → `ram_wen`=1, `ram_store`=`dmemstore`, `ram_ren`=0; else `ram_ren`=1. REN and WEN both high: write wins.
- In an access state with `ram_ready`=1: `ihit` (IACC) or `dhit` (DACC) = 1 same cycle; `imemload`/`dmemload` = `ram_load` combinationally; next state IDLE.
- `imemload`/`dmemload` = 0 when the matching hit is low.
- Outside access states `ram_ren`, `ram_wen`, `ram_addr`, `ram_store` = 0; never both strobes high.
- Requester dropping its request mid-grant: strobes drop that cycle, state → IDLE next edge, no hit, `cnt` cleared.
- `halt` rising during IACC: in-flight fetch completes normally; no further IACC grants while `halt`=1. Data grants unaffected.
- Timeout: `cnt` clears on entry to an access state, increments each access cycle without `ram_ready`. When `cnt`=TIMEOUT-1 and `ram_ready`=0: no hit, `err`←1, next state IDLE. `err` clears only on reset.
- `ram_ready` outside access states ignored.

## Timing
- Reset (edge with `RST`=1): state IDLE, `last_d`=0, `cnt`=0, `err`=0; hence all strobes, hits, loads, address/store = 0 from the following cycle. Reset mid-access aborts without hit.
- Grant latency: request seen in IDLE at cycle n → strobe in cycle n+1.
- Min access: `ram_ready` in cycle n+1 → hit in cycle n+1, IDLE in n+2. Held request regranted with strobe in n+3.
- Each access: exactly one hit pulse or one timeout; no back-to-back hits from one grant.
- Timeout grant occupies exactly TIMEOUT cycles of strobe.

## Test plan
- Reset then `imemREN`=1, `imemaddr`=0x100, `ram_ready` one cycle after strobe, `ram_load`=0xDEADBEEF → `ram_ren`=1 at cycle 1, `ihit`=1 and `imemload`=0xDEADBEEF same cycle, IDLE next.
- `imemREN` and `dmemWEN` both held from reset, `dmemaddr`=0x200, `dmemstore`=0x55 → first grant DACC (`last_d`=0), `ram_wen`=1 with 0x200/0x55, `dhit`; next grant IACC; grants alternate I/D while both held.
- `dmemREN`=`dmemWEN`=1 → only `ram_wen` asserts; `dhit`=1, `dmemload`=0.
- `halt`=1 with `imemREN`=1, `dmemREN`=1 → DACC only, never `ram_ren` at `imemaddr`; `halt` asserted mid-IACC → that fetch still produces `ihit`.
- `ram_ready` held 0 with TIMEOUT=16 → strobe for exactly 16 cycles, no hit, `err`=1 and stays 1 through later successful accesses until `RST`.
- `RST` pulsed in 2nd cycle of a DACC → strobes 0 next cycle, no `dhit`, `err`=0, `last_d`=0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - request-unit / RAM signal bundle for mem_arbiter
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // Request unit / CPU side
  logic          imemREN;
  logic [AW-1:0] imemaddr;
  logic          dmemREN;
  logic          dmemWEN;
  logic [AW-1:0] dmemaddr;
  logic [DW-1:0] dmemstore;
  logic          halt;
  logic          ihit;
  logic          dhit;
  logic [DW-1:0] imemload;
  logic [DW-1:0] dmemload;
  logic          err;

  // RAM side
  logic          ram_ready;
  logic [DW-1:0] ram_load;
  logic          ram_ren;
  logic          ram_wen;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_store;

  // Environment view: drives requests and RAM responses
  modport master (
    output imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, halt,
    output ram_ready, ram_load,
    input  ram_ren, ram_wen, ram_addr, ram_store,
    input  ihit, dhit, imemload, dmemload, err
  );

  // Arbiter view
  modport slave (
    input  imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, halt,
    input  ram_ready, ram_load,
    output ram_ren, ram_wen, ram_addr, ram_store,
    output ihit, dhit, imemload, dmemload, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin I/D arbiter for a single-ported RAM with timeout
module mem_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic          CLK,
  input  logic          RST,
  mem_arbiter_if.slave  bus
);

  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          last_d, last_d_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          err_q, err_nxt;

  logic          dreq;
  logic          ireq;
  logic          serving;

  // Halt only gates instruction grants; an in-flight fetch is tracked via imemREN alone
  assign dreq = bus.dmemREN | bus.dmemWEN;
  assign ireq = bus.imemREN & ~halt_q_unused_free();

  function automatic logic halt_q_unused_free();
    return bus.halt;
  endfunction

  assign bus.err = err_q;

  // Grant selection, RAM strobes, hit/load return and timeout accounting
  always_comb begin
    state_nxt     = state;
    last_d_nxt    = last_d;
    cnt_nxt       = cnt;
    err_nxt       = err_q;
    serving       = 1'b0;
    bus.ram_ren   = 1'b0;
    bus.ram_wen   = 1'b0;
    bus.ram_addr  = {AW{1'b0}};
    bus.ram_store = {DW{1'b0}};
    bus.ihit      = 1'b0;
    bus.dhit      = 1'b0;
    bus.imemload  = {DW{1'b0}};
    bus.dmemload  = {DW{1'b0}};

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        // On contention the side that did not go last wins
        if (dreq && (!ireq || !last_d)) begin
          state_nxt  = DACC;
          last_d_nxt = 1'b1;
        end else if (ireq) begin
          state_nxt  = IACC;
          last_d_nxt = 1'b0;
        end
      end

      IACC: begin
        if (bus.imemREN) begin
          serving      = 1'b1;
          bus.ram_ren  = 1'b1;
          bus.ram_addr = bus.imemaddr;
          if (bus.ram_ready) begin
            bus.ihit     = 1'b1;
            bus.imemload = bus.ram_load;
          end
        end
      end

      DACC: begin
        if (dreq) begin
          serving      = 1'b1;
          bus.ram_addr = bus.dmemaddr;
          if (bus.dmemWEN) begin
            // Write wins when both REN and WEN are raised
            bus.ram_wen   = 1'b1;
            bus.ram_store = bus.dmemstore;
          end else begin
            bus.ram_ren = 1'b1;
          end
          if (bus.ram_ready) begin
            bus.dhit = 1'b1;
            // A write returns no load data
            if (!bus.dmemWEN) begin
              bus.dmemload = bus.ram_load;
            end
          end
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // Leaving an access state: completion, requester withdrawal, or timeout
    if (state == IACC || state == DACC) begin
      if (!serving || bus.ram_ready) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end else if (cnt == CNT_LAST) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        err_nxt   = 1'b1;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  // State, fairness flag, timeout counter and sticky error registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      last_d <= 1'b0;
      cnt    <= '0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      last_d <= last_d_nxt;
      cnt    <= cnt_nxt;
      err_q  <= err_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter against a grant-level model
module tb_mem_arbiter;

  localparam int TO = 16;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  mem_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_arbiter #(.TIMEOUT(TO), .AW(32), .DW(32)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: who holds the RAM (0 none, 1 fetch, 2 data), how long, who went last
  int owner  = 0;
  int age    = 0;
  bit d_last = 1'b0;
  bit m_err  = 1'b0;

  // Last observed DUT outputs, for directed checks
  logic        obs_ren, obs_wen, obs_ihit, obs_dhit, obs_err;
  logic [31:0] obs_addr, obs_store, obs_iload, obs_dload;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.imemREN   = 1'b0;
    bus.imemaddr  = '0;
    bus.dmemREN   = 1'b0;
    bus.dmemWEN   = 1'b0;
    bus.dmemaddr  = '0;
    bus.dmemstore = '0;
    bus.halt      = 1'b0;
    bus.ram_ready = 1'b0;
    bus.ram_load  = '0;
  endtask

  // One clock: compare outputs at the falling edge, then advance the model across the rising edge
  task automatic tick();
    logic        e_ren, e_wen, e_ih, e_dh;
    logic [31:0] e_addr, e_store, e_il, e_dl;
    bit          dreq, ireq, still;
    @(negedge CLK);
    e_ren = 0; e_wen = 0; e_ih = 0; e_dh = 0;
    e_addr = '0; e_store = '0; e_il = '0; e_dl = '0;
    dreq = bus.dmemREN | bus.dmemWEN;
    ireq = bus.imemREN & ~bus.halt;
    if (owner == 1 && bus.imemREN) begin
      e_ren  = 1;
      e_addr = bus.imemaddr;
      if (bus.ram_ready) begin
        e_ih = 1;
        e_il = bus.ram_load;
      end
    end
    if (owner == 2 && dreq) begin
      e_addr = bus.dmemaddr;
      if (bus.dmemWEN) begin
        e_wen   = 1;
        e_store = bus.dmemstore;
      end else begin
        e_ren = 1;
      end
      if (bus.ram_ready) begin
        e_dh = 1;
        e_dl = bus.dmemWEN ? 32'h0 : bus.ram_load;
      end
    end
    obs_ren = bus.ram_ren;   obs_wen = bus.ram_wen;   obs_addr = bus.ram_addr;
    obs_store = bus.ram_store; obs_ihit = bus.ihit;   obs_dhit = bus.dhit;
    obs_iload = bus.imemload;  obs_dload = bus.dmemload; obs_err = bus.err;
    check_eq("ram_ren",   obs_ren,   e_ren);
    check_eq("ram_wen",   obs_wen,   e_wen);
    check_eq("ram_addr",  obs_addr,  e_addr);
    check_eq("ram_store", obs_store, e_store);
    check_eq("ihit",      obs_ihit,  e_ih);
    check_eq("dhit",      obs_dhit,  e_dh);
    check_eq("imemload",  obs_iload, e_il);
    check_eq("dmemload",  obs_dload, e_dl);
    check_eq("err",       obs_err,   m_err);
    if (RST) begin
      owner = 0; age = 0; d_last = 0; m_err = 0;
    end else if (owner == 0) begin
      age = 0;
      if (dreq && (!ireq || !d_last)) begin
        owner = 2; d_last = 1;
      end else if (ireq) begin
        owner = 1; d_last = 0;
      end
    end else begin
      still = (owner == 1) ? bus.imemREN : dreq;
      if (!still || bus.ram_ready) begin
        owner = 0;
      end else if (age == TO - 1) begin
        owner = 0; m_err = 1;
      end else begin
        age++;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int gseq[$];
    int n_ig, n_dh, n_ren, p_ready, p_chg;

    idle_inputs();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;

    // Reset state, then single fetch with immediate ready
    tick();
    bus.imemREN = 1; bus.imemaddr = 32'h100; bus.ram_load = 32'hDEADBEEF;
    tick();
    check_eq("t1_grant_cycle_ren", obs_ren, 0);
    bus.ram_ready = 1;
    tick();
    check_eq("t1_ren", obs_ren, 1);
    check_eq("t1_addr", obs_addr, 32'h100);
    check_eq("t1_ihit", obs_ihit, 1);
    check_eq("t1_iload", obs_iload, 32'hDEADBEEF);
    bus.imemREN = 0; bus.ram_ready = 0;
    tick();
    check_eq("t1_idle_ren", obs_ren, 0);

    // Both held from reset: data first, then strict alternation
    RST = 1; tick(); RST = 0;
    bus.imemREN = 1; bus.imemaddr = 32'h180;
    bus.dmemWEN = 1; bus.dmemaddr = 32'h200; bus.dmemstore = 32'h55; bus.ram_ready = 1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (obs_wen) begin
        if (gseq.size() == 0) begin
          check_eq("alt_addr", obs_addr, 32'h200);
          check_eq("alt_store", obs_store, 32'h55);
          check_eq("alt_dhit", obs_dhit, 1);
        end
        gseq.push_back(2);
      end else if (obs_ren) begin
        gseq.push_back(1);
      end
    end
    check_eq("alt_count", gseq.size(), 4);
    for (int k = 0; k < gseq.size(); k++) check_eq("alt_order", gseq[k], (k % 2 == 0) ? 2 : 1);
    idle_inputs();
    tick();

    // REN and WEN together: write only, no load data
    bus.dmemREN = 1; bus.dmemWEN = 1; bus.dmemaddr = 32'h240; bus.dmemstore = 32'h1234;
    bus.ram_load = 32'hCAFEF00D; bus.ram_ready = 1;
    tick();
    tick();
    check_eq("rw_wen", obs_wen, 1);
    check_eq("rw_ren", obs_ren, 0);
    check_eq("rw_dhit", obs_dhit, 1);
    check_eq("rw_dload", obs_dload, 0);
    idle_inputs();
    tick();

    // Halt blocks fetch grants, data still served
    bus.halt = 1; bus.imemREN = 1; bus.imemaddr = 32'h300;
    bus.dmemREN = 1; bus.dmemaddr = 32'h400; bus.ram_ready = 1;
    n_ig = 0; n_dh = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (obs_ren && obs_addr == 32'h300) n_ig++;
      if (obs_dhit) n_dh++;
    end
    check_eq("halt_no_fetch", n_ig, 0);
    check_eq("halt_dhits", n_dh, 5);

    // Halt raised mid-fetch: the fetch still completes
    bus.halt = 0; bus.dmemREN = 0; bus.ram_ready = 0;
    tick();
    tick();
    check_eq("halt_mid_ren", obs_ren, 1);
    bus.halt = 1; bus.ram_ready = 1;
    tick();
    check_eq("halt_mid_ihit", obs_ihit, 1);
    idle_inputs();
    tick();

    // Timeout: exactly TO strobe cycles, no hit, sticky err
    bus.imemREN = 1; bus.imemaddr = 32'h500;
    n_ren = 0; n_ig = 0;
    for (int k = 0; k < 17; k++) begin
      tick();
      if (obs_ren) n_ren++;
      if (obs_ihit) n_ig++;
    end
    bus.imemREN = 0;
    tick();
    if (obs_ren) n_ren++;
    check_eq("to_strobe_cycles", n_ren, TO);
    check_eq("to_no_hit", n_ig, 0);
    check_eq("to_err", obs_err, 1);
    bus.dmemREN = 1; bus.dmemaddr = 32'h540; bus.ram_ready = 1;
    tick();
    tick();
    check_eq("to_later_dhit", obs_dhit, 1);
    check_eq("to_err_sticky", obs_err, 1);
    idle_inputs();
    tick();

    // Reset in the 2nd cycle of a data access
    bus.dmemREN = 1; bus.dmemaddr = 32'h600;
    tick();
    tick();
    RST = 1;
    tick();
    RST = 0;
    bus.imemREN = 1; bus.imemaddr = 32'h700; bus.ram_ready = 1;
    tick();
    check_eq("rst_ren", obs_ren, 0);
    check_eq("rst_dhit", obs_dhit, 0);
    check_eq("rst_err", obs_err, 0);
    tick();
    check_eq("rst_last_d_addr", obs_addr, 32'h600);
    check_eq("rst_last_d_dhit", obs_dhit, 1);
    idle_inputs();
    tick();

    // Randomized traffic in segments of varying RAM readiness and request churn
    for (int seg = 0; seg < 60; seg++) begin
      case ($urandom_range(3))
        0: p_ready = 0;
        1: p_ready = 15;
        2: p_ready = 50;
        default: p_ready = 90;
      endcase
      p_chg = ($urandom_range(1) == 0) ? 4 : 30;
      for (int c = 0; c < 40; c++) begin
        if ($urandom_range(99) < p_chg) bus.imemREN = $urandom_range(1);
        if ($urandom_range(99) < p_chg) bus.dmemREN = $urandom_range(1);
        if ($urandom_range(99) < p_chg) bus.dmemWEN = $urandom_range(1);
        if ($urandom_range(99) < 5)     bus.halt    = ~bus.halt;
        bus.imemaddr  = $urandom;
        bus.dmemaddr  = $urandom;
        bus.dmemstore = $urandom;
        bus.ram_load  = $urandom;
        bus.ram_ready = ($urandom_range(99) < p_ready);
        RST = ($urandom_range(399) == 0);
        tick();
      end
    end
    RST = 0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
